// File: rtl/dynamic_seg_adder_pkg.sv
// Shared definitions for the segmented early-terminating adder.
//  - state_e : controller states (IDLE, CALC, DONE)
//  - nseg()  : number of ripple segments for a given width / segment width
//  - cw()    : width of the compute-cycle counter able to hold 0..NSEG
package dynamic_seg_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int nseg(input int n, input int seg);
        return n / seg;
    endfunction

    function automatic int cw(input int ns);
        return $clog2(ns + 1);
    endfunction

endpackage

// File: rtl/dynamic_seg_adder_if.sv
// Operand / result channel of the segmented adder.
//  Request : in_valid, in_ready, a, b, cin
//  Response: out_valid, out_ready, s, p, cout, cycles
//  master drives requests and accepts results; slave is the adder.
interface dynamic_seg_adder_if #(
    parameter int N  = 16,
    parameter int CW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          cin;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  s;
    logic [N-1:0]  p;
    logic          cout;
    logic [CW-1:0] cycles;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, s, p, cout, cycles
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, s, p, cout, cycles
    );
endinterface

// File: rtl/dynamic_seg_adder_rca.sv
// Combinational ripple-carry adder segment.
//  a_i, b_i : N-bit operands     cin_i  : carry in
//  sum_o    : N-bit sum          cout_o : carry out
//  p_o      : per-bit propagate (a_i ^ b_i)
module dynamic_seg_adder_rca #(
    parameter int N = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o,
    output logic [N-1:0] p_o
);
    logic carry_s;

    assign p_o = a_i ^ b_i;

    // Bit-serial ripple of the carry through the segment
    always_comb begin
        carry_s = cin_i;
        sum_o   = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            sum_o[i] = p_o[i] ^ carry_s;
            carry_s  = (a_i[i] & b_i[i]) | (carry_s & p_o[i]);
        end
        cout_o = carry_s;
    end
endmodule

// File: rtl/dynamic_seg_adder.sv
// Variable-latency N-bit adder made of NSEG = N/SEG ripple segments.
// All segments evaluate every cycle from a registered inter-segment carry
// vector; the add finishes once those carries reach their fixed point
// (EARLY=1) or after NSEG cycles (EARLY=0).
//  clk, rst : clock, synchronous active-high reset
//  bus      : slave side of dynamic_seg_adder_if (operands in, S/P/Cout/cycles out)
module dynamic_seg_adder
    import dynamic_seg_adder_pkg::*;
#(
    parameter int N     = 16,
    parameter int SEG   = 4,
    parameter int EARLY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    dynamic_seg_adder_if.slave   bus
);
    localparam int NSEG = nseg(N, SEG);
    localparam int CW   = cw(NSEG);
    localparam logic [CW-1:0] LAST_ITER = CW'(NSEG - 1);

    if ((N % SEG) != 0 || SEG < 1 || SEG > N) begin : g_bad_cfg
        $error("dynamic_seg_adder: N must be a positive multiple of SEG");
    end

    state_e          state_q, state_d;
    logic [N-1:0]    a_q, b_q;
    logic [NSEG-1:0] c_q;        // carry into each segment; c_q[0] is Cin
    logic [CW-1:0]   iter_q;
    logic [N-1:0]    s_q, p_q;
    logic            cout_q;
    logic [CW-1:0]   cycles_q;
    logic            out_valid_q;

    logic [N-1:0]    sum_s, p_s;
    logic [NSEG-1:0] co_s;
    logic [NSEG-1:0] c_next_s;
    logic            stable_s;
    logic            done_s;
    logic            load_s, step_s, finish_s, release_s;

    for (genvar i = 0; i < NSEG; i++) begin : g_seg
        dynamic_seg_adder_rca #(.N(SEG)) u_rca (
            .a_i   (a_q[i*SEG +: SEG]),
            .b_i   (b_q[i*SEG +: SEG]),
            .cin_i (c_q[i]),
            .sum_o (sum_s[i*SEG +: SEG]),
            .cout_o(co_s[i]),
            .p_o   (p_s[i*SEG +: SEG])
        );
    end

    // A single segment has no internal carries, so it is always settled.
    if (NSEG == 1) begin : g_one_seg
        assign stable_s = 1'b1;
        assign c_next_s = c_q;
    end else begin : g_multi_seg
        assign stable_s = (co_s[NSEG-2:0] == c_q[NSEG-1:1]);
        assign c_next_s = {co_s[NSEG-2:0], c_q[0]};
    end

    assign done_s = (EARLY != 0) ? stable_s : (iter_q == LAST_ITER);

    // Next-state and control strobes for IDLE -> CALC -> DONE
    always_comb begin
        state_d   = state_q;
        load_s    = 1'b0;
        step_s    = 1'b0;
        finish_s  = 1'b0;
        release_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    load_s  = 1'b1;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                step_s = 1'b1;
                if (done_s) begin
                    finish_s = 1'b1;
                    state_d  = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    release_s = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand, carry and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= {N{1'b0}};
            b_q         <= {N{1'b0}};
            c_q         <= {NSEG{1'b0}};
            iter_q      <= {CW{1'b0}};
            s_q         <= {N{1'b0}};
            p_q         <= {N{1'b0}};
            cout_q      <= 1'b0;
            cycles_q    <= {CW{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_s) begin
                a_q    <= bus.a;
                b_q    <= bus.b;
                c_q    <= NSEG'(bus.cin);
                iter_q <= {CW{1'b0}};
            end
            if (step_s) begin
                c_q    <= c_next_s;
                iter_q <= iter_q + CW'(1);
            end
            if (finish_s) begin
                s_q         <= sum_s;
                p_q         <= p_s;
                cout_q      <= co_s[NSEG-1];
                cycles_q    <= iter_q + CW'(1);
                out_valid_q <= 1'b1;
            end
            if (release_s) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // in_ready follows the state register but is forced low during reset.
    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign bus.p         = p_q;
    assign bus.cout      = cout_q;
    assign bus.cycles    = cycles_q;
endmodule

// File: tb/tb_dynamic_seg_adder.sv
module tb_dynamic_seg_adder;
    localparam int N    = 16;
    localparam int SEG  = 4;
    localparam int NSEG = N / SEG;
    localparam int CW   = $clog2(NSEG + 1);

    typedef struct {
        logic [N-1:0] s;
        logic [N-1:0] p;
        logic         cout;
        int           cyc;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc_cnt = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q_e[$];
    exp_t q_w[$];

    dynamic_seg_adder_if #(.N(N), .CW(CW)) if_e ();
    dynamic_seg_adder_if #(.N(N), .CW(CW)) if_w ();

    dynamic_seg_adder #(.N(N), .SEG(SEG), .EARLY(1)) u_dut_e (
        .clk(clk), .rst(rst), .bus(if_e)
    );
    dynamic_seg_adder #(.N(N), .SEG(SEG), .EARLY(0)) u_dut_w (
        .clk(clk), .rst(rst), .bus(if_w)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: golden sum, and latency from how far each carry must travel.
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic cin, input bit early);
        exp_t x;
        int total, prev_rdy, r, k, m, ct, sa, sb;
        total  = int'(a) + int'(b) + int'(cin);
        x.s    = total[N-1:0];
        x.cout = total[N];
        x.p    = a ^ b;
        x.acc  = 0;
        k = 1;
        prev_rdy = 1;
        for (int i = 1; i < NSEG; i++) begin
            m  = (1 << (SEG * i)) - 1;
            ct = (((int'(a) & m) + (int'(b) & m) + int'(cin)) >> (SEG * i)) & 1;
            sa = (int'(a) >> (SEG * (i - 1))) & ((1 << SEG) - 1);
            sb = (int'(b) >> (SEG * (i - 1))) & ((1 << SEG) - 1);
            if (ct == 0)                  r = 1;
            else if (sa + sb >= (1 << SEG)) r = 2;
            else                          r = prev_rdy + 1;
            if (r > k) k = r;
            prev_rdy = r;
        end
        x.cyc = early ? k : NSEG;
        return x;
    endfunction

    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic cin, input bit track);
        int t = 0;
        exp_t x;
        while (!(if_e.in_ready === 1'b1 && if_w.in_ready === 1'b1) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout actual=busy expected=in_ready");
            return;
        end
        if_e.a = a; if_e.b = b; if_e.cin = cin; if_e.in_valid = 1'b1;
        if_w.a = a; if_w.b = b; if_w.cin = cin; if_w.in_valid = 1'b1;
        if (track) begin
            x = model(a, b, cin, 1'b1); x.acc = cyc_cnt + 1; q_e.push_back(x);
            x = model(a, b, cin, 1'b0); x.acc = cyc_cnt + 1; q_w.push_back(x);
        end
        @(negedge clk);
        if_e.in_valid = 1'b0;
        if_w.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(q_e.size() == 0 && q_w.size() == 0 &&
                 if_e.in_ready === 1'b1 && if_w.in_ready === 1'b1) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=pending%0d expected=pending0", q_e.size() + q_w.size());
        end
    endtask

    // Monitor for the early-termination instance: compare on each new result.
    initial begin
        logic prev = 1'b0;
        exp_t x;
        forever begin
            @(negedge clk);
            if (if_e.out_valid === 1'b1 && prev !== 1'b1) begin
                if (q_e.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL e_unexpected actual=out_valid expected=no_result");
                end else begin
                    x = q_e.pop_front();
                    check("e_S", 32'(if_e.s), 32'(x.s));
                    check("e_P", 32'(if_e.p), 32'(x.p));
                    check("e_Cout", 32'(if_e.cout), 32'(x.cout));
                    check("e_cycles", 32'(if_e.cycles), 32'(x.cyc));
                    check("e_latency", 32'(cyc_cnt - x.acc), 32'(x.cyc));
                end
            end
            prev = if_e.out_valid;
        end
    end

    // Monitor for the worst-case instance.
    initial begin
        logic prev = 1'b0;
        exp_t x;
        forever begin
            @(negedge clk);
            if (if_w.out_valid === 1'b1 && prev !== 1'b1) begin
                if (q_w.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL w_unexpected actual=out_valid expected=no_result");
                end else begin
                    x = q_w.pop_front();
                    check("w_S", 32'(if_w.s), 32'(x.s));
                    check("w_P", 32'(if_w.p), 32'(x.p));
                    check("w_Cout", 32'(if_w.cout), 32'(x.cout));
                    check("w_cycles", 32'(if_w.cycles), 32'(x.cyc));
                    check("w_latency", 32'(cyc_cnt - x.acc), 32'(x.cyc));
                end
            end
            prev = if_w.out_valid;
        end
    end

    initial begin
        logic [N-1:0] s_hold, ra, rb;
        int t;
        if_e.in_valid = 1'b0; if_e.a = '0; if_e.b = '0; if_e.cin = 1'b0; if_e.out_ready = 1'b1;
        if_w.in_valid = 1'b0; if_w.a = '0; if_w.b = '0; if_w.cin = 1'b0; if_w.out_ready = 1'b1;

        // Reset held for two cycles
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(if_e.in_ready), 32'd0);
        check("rst_out_valid", 32'(if_e.out_valid), 32'd0);
        check("rst_S", 32'(if_e.s), 32'd0);
        check("rst_cycles", 32'(if_e.cycles), 32'd0);
        check("rst_w_out_valid", 32'(if_w.out_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(if_e.in_ready), 32'd1);

        // Directed cases
        issue(16'h1234, 16'h4321, 1'b0, 1'b1);
        issue(16'h00FF, 16'h0001, 1'b0, 1'b1);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        issue(16'h0000, 16'h0000, 1'b1, 1'b1);
        issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        wait_idle();

        // Result backpressure with a competing request
        if_e.out_ready = 1'b0;
        if_w.out_ready = 1'b0;
        issue(16'h0F0F, 16'h00F1, 1'b0, 1'b1);
        t = 0;
        while (if_e.out_valid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        check("bp_out_valid_seen", 32'(if_e.out_valid), 32'd1);
        s_hold = if_e.s;
        if_e.a = 16'hAAAA; if_e.b = 16'h5555; if_e.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid_held", 32'(if_e.out_valid), 32'd1);
            check("bp_S_held", 32'(if_e.s), 32'(s_hold));
            check("bp_in_ready_low", 32'(if_e.in_ready), 32'd0);
        end
        if_e.in_valid = 1'b0;
        t = 0;
        while (if_w.out_valid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        if_e.out_ready = 1'b1;
        if_w.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 32'(if_e.in_ready), 32'd1);
        check("bp_release_out_valid", 32'(if_e.out_valid), 32'd0);
        check("bp_S_kept", 32'(if_e.s), 32'(s_hold));

        // Reset in the 2nd compute cycle abandons the add
        wait_idle();
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_out_valid", 32'(if_e.out_valid | if_w.out_valid), 32'd0);
        end
        check("abort_in_ready", 32'(if_e.in_ready), 32'd1);
        issue(16'h7FFF, 16'h0001, 1'b1, 1'b1);

        // Random back-to-back traffic with carry-chain biased patterns
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = 16'($urandom);
                1:       rb = ~ra;
                default: begin ra = ra | 16'h0FFF; rb = 16'($urandom_range(0, 3)); end
            endcase
            issue(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
        end
        wait_idle();
        check("queues_drained", 32'(q_e.size() + q_w.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
